fifo_pkt_arbiter: RTL and testbench
===================================

FIFO_PKT_ARBITER -- requirements
Module: fifo_pkt_arbiter

Interface
REQ-001 SHALL have parameter Width, default 9, giving the FIFO word width; bit Width-1 is the end-of-packet (EOP) flag.
REQ-002 SHALL have parameter StatWidth, default 16, giving the width of the packet counters.
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Req0Valid / Req1Valid  input  1  requester word valid.
REQ-006 SHALL have port Req0Data / Req1Data  input  Width  requester word, EOP in MSB.
REQ-007 SHALL have port Req0Ready / Req1Ready  output  1  word accepted when Valid and Ready are both high.
REQ-008 SHALL have port FifoWrite  output  1  write strobe to the block-RAM FIFO.
REQ-009 SHALL have port FifoDin  output  Width  write data to the FIFO.
REQ-010 SHALL have port FifoFull  input  1  FIFO full flag.
REQ-011 SHALL have port FifoProgFull  input  1  FIFO programmable-full flag.
REQ-012 SHALL have port Grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 SHALL have port PktCount0 / PktCount1  output  StatWidth  completed-packet counters (see REQ-030).

Function
REQ-014 SHALL implement states IDLE, OWN0 and OWN1, with Grant = 00/01/10 respectively, decoded directly from state.
REQ-015 In IDLE with FifoProgFull low, SHALL move to OWN0 or OWN1 for a requester with Valid high, choosing by the round-robin pointer when both are valid.
REQ-016 In IDLE with FifoProgFull high, SHALL stay in IDLE regardless of requests.
REQ-017 Round-robin pointer SHALL select requester 0 when 0, requester 1 when 1; a lone valid requester SHALL win irrespective of the pointer.
REQ-018 Grant SHALL take effect the cycle after arbitration; one idle bubble per packet is required.
REQ-019 ReqNReady SHALL be combinational: high only in OWNN with FifoFull low; the non-owner's Ready SHALL be 0.
REQ-020 FifoWrite SHALL equal the owner's Valid AND Ready, combinationally; FifoDin SHALL equal the owner's Data, or all zeros when idle.
REQ-021 On an accepted word with EOP=1, SHALL return to IDLE next cycle and set the pointer to the other requester.
REQ-022 A single-word packet (first word has EOP) SHALL be accepted and release ownership identically.
REQ-023 FifoFull high mid-packet SHALL stall (Ready low) with ownership held; FifoProgFull SHALL NOT affect an owned packet.
REQ-024 Owner Valid low mid-packet SHALL hold ownership indefinitely; no timeout.
REQ-025 SHALL never assert FifoWrite while FifoFull is high.

Reset
REQ-026 Reset SHALL force state IDLE, Grant 00, pointer 0, Req0Ready/Req1Ready 0, FifoWrite 0, FifoDin 0.
REQ-027 Reset mid-packet SHALL abandon the packet without writing a terminating word; FIFO recovery is the FIFO's own Reset.
REQ-028 Reset SHALL override a simultaneous accepted word; the accepted word still reaches the FIFO in that cycle (combinational path) but no state updates.

Configuration
REQ-029 Macro FIFO_PKT_ARB_STATS_EN SHALL compile in the packet counters.
REQ-030 With FIFO_PKT_ARB_STATS_EN defined, PktCountN SHALL increment by 1 on each accepted EOP word from requester N, wrap modulo 2^StatWidth, and reset to 0.
REQ-031 Without FIFO_PKT_ARB_STATS_EN, PktCount0/PktCount1 SHALL be tied to 0 and no counter registers SHALL exist.

Structure
REQ-032 A shared package fifo_pkt_arb_pkg SHALL hold the state encoding (IDLE=0, OWN0=1, OWN1=2) and the Grant one-hot constants.
REQ-033 The block SHALL be a single module with no sub-modules; the FIFO is instantiated by the parent, not inside this block.

Verification
REQ-034 Req0 sends a 3-word packet (0x011, 0x022, 0x123) with the FIFO empty -> Grant 01 on cycle 1, three FifoWrite pulses with FifoDin 0x011/0x022/0x123, IDLE the cycle after 0x123.
REQ-035 Both requesters are valid in IDLE after reset -> OWN0 first; after its EOP, OWN1 follows with one bubble cycle; then the pointer returns to 0.
REQ-036 FifoFull is high for 4 cycles mid-packet -> Ready and FifoWrite are 0 for those 4 cycles, Grant unchanged, and no words are lost or duplicated.
REQ-037 FifoProgFull is high in IDLE while Req1 is valid -> Grant stays 00; when ProgFull drops, Grant becomes 10 the next cycle.
REQ-038 Reset pulses during the second word of a packet -> next cycle Grant 00, pointer 0, and PktCount0 unchanged (with FIFO_PKT_ARB_STATS_EN).
REQ-039 With FIFO_PKT_ARB_STATS_EN and StatWidth=4, send 17 single-word packets from Req1 -> PktCount1 is 1 (wrap) and PktCount0 is 0.

Source files
------------

// File: rtl/fifo_pkt_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkt_arb_pkg
// Shared definitions for the two-requester packet arbiter that feeds a
// block-RAM FIFO.
//   state_t     : arbiter state encoding (IDLE=0, OWN0=1, OWN1=2)
//   GRANT_*     : one-hot Grant values presented to the parent
//   grantOf()   : state -> Grant decode
// ---------------------------------------------------------------------------
package fifo_pkt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    // Grant is a pure decode of the state register, so it changes exactly
    // one cycle after the arbitration decision.
    function automatic logic [1:0] grantOf(input state_t s);
        case (s)
            OWN0:    grantOf = GRANT_REQ0;
            OWN1:    grantOf = GRANT_REQ1;
            default: grantOf = GRANT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fifo_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_pkt_arbiter
// Round-robin, packet-atomic arbiter between two word streams writing into a
// single block-RAM FIFO. Once a requester owns the FIFO it keeps it until its
// end-of-packet word (data MSB) is accepted; the other requester gets the
// next packet after one idle bubble.
//
// Parameters
//   Width      FIFO word width, bit Width-1 is the EOP flag
//   StatWidth  width of the completed-packet counters
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   Req0Valid/Data/Ready       requester 0 valid/ready word stream
//   Req1Valid/Data/Ready       requester 1 valid/ready word stream
//   FifoWrite, FifoDin         FIFO write strobe and data
//   FifoFull, FifoProgFull     FIFO full / programmable-full flags
//   Grant                      one-hot current owner, 00 when idle
//   PktCount0, PktCount1       completed-packet counters per requester
//
// Build option
//   FIFO_PKT_ARB_STATS_EN  when defined, PktCount0/1 count accepted EOP words
//                          (wrapping); otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module fifo_pkt_arbiter
    import fifo_pkt_arb_pkg::*;
#(
    parameter int Width     = 9,
    parameter int StatWidth = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req0Valid,
    input  logic [Width-1:0]     Req0Data,
    output logic                 Req0Ready,
    input  logic                 Req1Valid,
    input  logic [Width-1:0]     Req1Data,
    output logic                 Req1Ready,
    output logic                 FifoWrite,
    output logic [Width-1:0]     FifoDin,
    input  logic                 FifoFull,
    input  logic                 FifoProgFull,
    output logic [1:0]           Grant,
    output logic [StatWidth-1:0] PktCount0,
    output logic [StatWidth-1:0] PktCount1
);

    state_t state_q;
    logic   rrPtr_q;
    logic   accept0;
    logic   accept1;
    logic   eop0;
    logic   eop1;

    // Ready depends only on ownership and FifoFull, so a full FIFO can never
    // see a write strobe. ProgFull is deliberately absent here: it only gates
    // the start of a new packet.
    always_comb begin
        Req0Ready = (state_q == OWN0) && !FifoFull;
        Req1Ready = (state_q == OWN1) && !FifoFull;
        accept0   = Req0Valid && Req0Ready;
        accept1   = Req1Valid && Req1Ready;
        eop0      = Req0Data[Width-1];
        eop1      = Req1Data[Width-1];
        FifoWrite = accept0 || accept1;
        case (state_q)
            OWN0:    FifoDin = Req0Data;
            OWN1:    FifoDin = Req1Data;
            default: FifoDin = '0;
        endcase
        Grant = grantOf(state_q);
    end

    // Arbitration FSM. The pointer names the requester favoured when both are
    // valid in IDLE; it flips to the other side whenever a packet finishes.
    // A word accepted in a reset cycle still reaches the FIFO through the
    // combinational path above, but reset wins over any state change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            rrPtr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!FifoProgFull) begin
                        if (Req0Valid && Req1Valid) begin
                            state_q <= rrPtr_q ? OWN1 : OWN0;
                        end else if (Req0Valid) begin
                            state_q <= OWN0;
                        end else if (Req1Valid) begin
                            state_q <= OWN1;
                        end
                    end
                end
                OWN0: begin
                    if (accept0 && eop0) begin
                        state_q <= IDLE;
                        rrPtr_q <= 1'b1;
                    end
                end
                OWN1: begin
                    if (accept1 && eop1) begin
                        state_q <= IDLE;
                        rrPtr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_PKT_ARB_STATS_EN
    logic [StatWidth-1:0] pktCount0_q;
    logic [StatWidth-1:0] pktCount1_q;

    // Counters advance on the accepted EOP word and wrap naturally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pktCount0_q <= '0;
            pktCount1_q <= '0;
        end else begin
            if (accept0 && eop0) begin
                pktCount0_q <= pktCount0_q + StatWidth'(1);
            end
            if (accept1 && eop1) begin
                pktCount1_q <= pktCount1_q + StatWidth'(1);
            end
        end
    end

    assign PktCount0 = pktCount0_q;
    assign PktCount1 = pktCount1_q;
`else
    assign PktCount0 = '0;
    assign PktCount1 = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_pkt_arbiter
// Directed testbench for fifo_pkt_arbiter (Width=9, StatWidth=4). Inputs are
// changed 1 time unit after the rising edge and outputs are inspected 1 unit
// later, well away from the next edge. Counter expectations follow the
// FIFO_PKT_ARB_STATS_EN build option.
// ---------------------------------------------------------------------------
module tb_fifo_pkt_arbiter;

    localparam int TbWidth = 9;
    localparam int TbStat  = 4;

    logic               Clk;
    logic               Reset;
    logic               Req0Valid;
    logic [TbWidth-1:0] Req0Data;
    logic               Req0Ready;
    logic               Req1Valid;
    logic [TbWidth-1:0] Req1Data;
    logic               Req1Ready;
    logic               FifoWrite;
    logic [TbWidth-1:0] FifoDin;
    logic               FifoFull;
    logic               FifoProgFull;
    logic [1:0]         Grant;
    logic [TbStat-1:0]  PktCount0;
    logic [TbStat-1:0]  PktCount1;

    int vectors;
    int miscompares;
    int writeCount;

    fifo_pkt_arbiter #(
        .Width     (TbWidth),
        .StatWidth (TbStat)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req0Valid    (Req0Valid),
        .Req0Data     (Req0Data),
        .Req0Ready    (Req0Ready),
        .Req1Valid    (Req1Valid),
        .Req1Data     (Req1Data),
        .Req1Ready    (Req1Ready),
        .FifoWrite    (FifoWrite),
        .FifoDin      (FifoDin),
        .FifoFull     (FifoFull),
        .FifoProgFull (FifoProgFull),
        .Grant        (Grant),
        .PktCount0    (PktCount0),
        .PktCount1    (PktCount1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (FifoWrite) writeCount <= writeCount + 1;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic clearInputs;
        Req0Valid    = 1'b0;
        Req0Data     = '0;
        Req1Valid    = 1'b0;
        Req1Data     = '0;
        FifoFull     = 1'b0;
        FifoProgFull = 1'b0;
    endtask

    task automatic doReset;
        clearInputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        clearInputs();
        Reset = 1'b1;
        tick();
        tick();
        #1;
        vectors++;
        if (Grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_grant: got %b expected 00", Grant);
        end
        vectors++;
        if ({Req0Ready, Req1Ready, FifoWrite} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready_write: got %b expected 000", {Req0Ready, Req1Ready, FifoWrite});
        end
        vectors++;
        if (FifoDin !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_din: got %h expected 000", FifoDin);
        end
        vectors++;
        if ({PktCount0, PktCount1} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: got %h expected 00", {PktCount0, PktCount1});
        end
        Reset = 1'b0;
    endtask

    task automatic test_three_word;
        int startWrites;
        doReset();
        startWrites = writeCount;
        Req0Valid = 1'b1;
        Req0Data  = 9'h011;
        #1;
        vectors++;
        if ({Grant, FifoWrite} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL tw_arb_cycle: got grant/write %b expected 000", {Grant, FifoWrite});
        end
        tick();
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b01, 1'b1, 9'h011}) begin
            miscompares++;
            $display("[TB] FAIL tw_word0: got grant %b write %b din %h expected 01 1 011", Grant, FifoWrite, FifoDin);
        end
        tick();
        Req0Data = 9'h022;
        #1;
        vectors++;
        if ({FifoWrite, FifoDin} !== {1'b1, 9'h022}) begin
            miscompares++;
            $display("[TB] FAIL tw_word1: got write %b din %h expected 1 022", FifoWrite, FifoDin);
        end
        tick();
        Req0Data = 9'h123;
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b01, 1'b1, 9'h123}) begin
            miscompares++;
            $display("[TB] FAIL tw_word2: got grant %b write %b din %h expected 01 1 123", Grant, FifoWrite, FifoDin);
        end
        tick();
        Req0Valid = 1'b0;
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b00, 1'b0, 9'h000}) begin
            miscompares++;
            $display("[TB] FAIL tw_release: got grant %b write %b din %h expected 00 0 000", Grant, FifoWrite, FifoDin);
        end
        vectors++;
        if (writeCount - startWrites !== 3) begin
            miscompares++;
            $display("[TB] FAIL tw_write_count: got %0d expected 3", writeCount - startWrites);
        end
    endtask

    task automatic test_round_robin;
        doReset();
        Req0Valid = 1'b1;
        Req0Data  = 9'h1AA;
        Req1Valid = 1'b1;
        Req1Data  = 9'h1BB;
        tick();
        #1;
        vectors++;
        if ({Grant, FifoDin, Req1Ready} !== {2'b01, 9'h1AA, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rr_first_owner: got grant %b din %h r1rdy %b expected 01 1aa 0", Grant, FifoDin, Req1Ready);
        end
        tick();
        #1;
        vectors++;
        if ({Grant, FifoWrite} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rr_bubble: got grant/write %b expected 000", {Grant, FifoWrite});
        end
        tick();
        #1;
        vectors++;
        if ({Grant, FifoDin, Req0Ready, FifoWrite} !== {2'b10, 9'h1BB, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rr_second_owner: got grant %b din %h r0rdy %b write %b expected 10 1bb 0 1", Grant, FifoDin, Req0Ready, FifoWrite);
        end
        tick();
        #1;
        vectors++;
        if (Grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rr_bubble2: got %b expected 00", Grant);
        end
        tick();
        #1;
        vectors++;
        if ({Grant, FifoDin} !== {2'b01, 9'h1AA}) begin
            miscompares++;
            $display("[TB] FAIL rr_pointer_back: got grant %b din %h expected 01 1aa", Grant, FifoDin);
        end
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
    endtask

    task automatic test_full_stall;
        int startWrites;
        doReset();
        startWrites = writeCount;
        Req0Valid = 1'b1;
        Req0Data  = 9'h001;
        tick();
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b01, 1'b1, 9'h001}) begin
            miscompares++;
            $display("[TB] FAIL fs_word0: got grant %b write %b din %h expected 01 1 001", Grant, FifoWrite, FifoDin);
        end
        tick();
        Req0Data     = 9'h002;
        FifoFull     = 1'b1;
        FifoProgFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({Grant, Req0Ready, FifoWrite} !== {2'b01, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL fs_stall%0d: got grant %b rdy %b write %b expected 01 0 0", i, Grant, Req0Ready, FifoWrite);
            end
            tick();
        end
        FifoFull = 1'b0;
        #1;
        vectors++;
        if ({Req0Ready, FifoWrite, FifoDin} !== {1'b1, 1'b1, 9'h002}) begin
            miscompares++;
            $display("[TB] FAIL fs_resume: got rdy %b write %b din %h expected 1 1 002", Req0Ready, FifoWrite, FifoDin);
        end
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b1;
        Req1Data  = 9'h1CC;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({Grant, FifoWrite, Req1Ready} !== {2'b01, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL fs_hold%0d: got grant %b write %b r1rdy %b expected 01 0 0", i, Grant, FifoWrite, Req1Ready);
            end
            tick();
        end
        Req0Valid = 1'b1;
        Req0Data  = 9'h003;
        Req1Valid = 1'b0;
        #1;
        vectors++;
        if ({FifoWrite, FifoDin} !== {1'b1, 9'h003}) begin
            miscompares++;
            $display("[TB] FAIL fs_word2: got write %b din %h expected 1 003", FifoWrite, FifoDin);
        end
        tick();
        Req0Data = 9'h104;
        tick();
        Req0Valid    = 1'b0;
        FifoProgFull = 1'b0;
        #1;
        vectors++;
        if (Grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL fs_release: got %b expected 00", Grant);
        end
        vectors++;
        if (writeCount - startWrites !== 4) begin
            miscompares++;
            $display("[TB] FAIL fs_write_count: got %0d expected 4", writeCount - startWrites);
        end
    endtask

    task automatic test_prog_full;
        doReset();
        FifoProgFull = 1'b1;
        Req1Valid    = 1'b1;
        Req1Data     = 9'h1DD;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            vectors++;
            if ({Grant, FifoWrite} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL pf_blocked%0d: got grant/write %b expected 000", i, {Grant, FifoWrite});
            end
        end
        FifoProgFull = 1'b0;
        tick();
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b10, 1'b1, 9'h1DD}) begin
            miscompares++;
            $display("[TB] FAIL pf_grant: got grant %b write %b din %h expected 10 1 1dd", Grant, FifoWrite, FifoDin);
        end
        tick();
        Req1Valid = 1'b0;
    endtask

    task automatic test_reset_mid_packet;
        doReset();
        Req0Valid = 1'b1;
        Req0Data  = 9'h1A1;
        tick();
        tick();
        Req0Data = 9'h011;
        tick();
        #1;
        vectors++;
        if ({Grant, FifoWrite, FifoDin} !== {2'b01, 1'b1, 9'h011}) begin
            miscompares++;
            $display("[TB] FAIL rm_lone_owner: got grant %b write %b din %h expected 01 1 011", Grant, FifoWrite, FifoDin);
        end
        tick();
        Req0Data = 9'h022;
        Reset    = 1'b1;
        #1;
        vectors++;
        if ({FifoWrite, FifoDin} !== {1'b1, 9'h022}) begin
            miscompares++;
            $display("[TB] FAIL rm_reset_write: got write %b din %h expected 1 022", FifoWrite, FifoDin);
        end
        tick();
        Reset     = 1'b0;
        Req0Data  = 9'h1EE;
        Req1Valid = 1'b1;
        Req1Data  = 9'h1FF;
        #1;
        vectors++;
        if ({Grant, PktCount0} !== {2'b00, 4'h0}) begin
            miscompares++;
            $display("[TB] FAIL rm_after_reset: got grant %b cnt0 %h expected 00 0", Grant, PktCount0);
        end
        tick();
        #1;
        vectors++;
        if ({Grant, FifoDin} !== {2'b01, 9'h1EE}) begin
            miscompares++;
            $display("[TB] FAIL rm_pointer_zero: got grant %b din %h expected 01 1ee", Grant, FifoDin);
        end
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
    endtask

    task automatic test_stat_wrap;
        int startWrites;
        logic [TbStat-1:0] expCount1;
`ifdef FIFO_PKT_ARB_STATS_EN
        expCount1 = 4'h1;
`else
        expCount1 = 4'h0;
`endif
        doReset();
        startWrites = writeCount;
        Req1Valid = 1'b1;
        Req1Data  = 9'h1B0;
        for (int i = 0; i < 17; i++) begin
            tick();
            tick();
        end
        Req1Valid = 1'b0;
        #1;
        vectors++;
        if (PktCount1 !== expCount1) begin
            miscompares++;
            $display("[TB] FAIL sw_count1: got %h expected %h", PktCount1, expCount1);
        end
        vectors++;
        if (PktCount0 !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL sw_count0: got %h expected 0", PktCount0);
        end
        vectors++;
        if (writeCount - startWrites !== 17) begin
            miscompares++;
            $display("[TB] FAIL sw_write_count: got %0d expected 17", writeCount - startWrites);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        writeCount  = 0;
        Reset       = 1'b1;
        clearInputs();
        test_reset();
        test_three_word();
        test_round_robin();
        test_full_stall();
        test_prog_full();
        test_reset_mid_packet();
        test_stat_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
